// File: rtl/top_level.sv
// Single-cycle LEGv8-subset core: PC, instruction ROM, 32x64 register file,
// ALU with {V,C,N,Z} status, data RAM and hardwired decode into a 32-bit control word.

module regfile (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [63:0] wd_i,
    input  logic [4:0]  ra_i,
    input  logic [4:0]  rb_i,
    output logic [63:0] a_o,
    output logic [63:0] b_o
);
    logic [63:0] registers [32];

    // X31 is the zero register: never written, always reads 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) registers[i] <= '0;
        end else if (we_i && (wa_i != 5'd31)) begin
            registers[wa_i] <= wd_i;
        end
    end

    assign a_o = (ra_i == 5'd31) ? 64'd0 : registers[ra_i];
    assign b_o = (rb_i == 5'd31) ? 64'd0 : registers[rb_i];
endmodule

module top_level #(
    parameter              ROM_FILE  = "program.hex",
    parameter int          ROM_WORDS = 64,
    parameter int          RAM_WORDS = 256,
    parameter logic [31:0] ROM_IMAGE [ROM_WORDS] = '{default: 32'h0}
) (
    input logic clock,
    input logic reset
);
    localparam int ROM_AW = $clog2(ROM_WORDS);
    localparam int RAM_AW = $clog2(RAM_WORDS);

    localparam logic [3:0] FS_AND = 4'd0, FS_ORR = 4'd1, FS_ADD = 4'd2, FS_SUB = 4'd3,
                           FS_EOR = 4'd4, FS_LSL = 4'd5, FS_LSR = 4'd6, FS_PSB = 4'd7;

    localparam logic [10:0] OP_ADD  = 11'b10001011000, OP_SUB  = 11'b11001011000,
                            OP_AND  = 11'b10001010000, OP_ORR  = 11'b10101010000,
                            OP_EOR  = 11'b11001010000, OP_ADDS = 11'b10101011000,
                            OP_SUBS = 11'b11101011000, OP_LSL  = 11'b11010011011,
                            OP_LSR  = 11'b11010011010, OP_LDUR = 11'b11111000010,
                            OP_STUR = 11'b11111000000;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100, OP_SUBI = 10'b1101000100,
                            OP_ANDI = 10'b1001001000, OP_ORRI = 10'b1011001000,
                            OP_EORI = 10'b1101001000;
    localparam logic [8:0]  OP_MOVZ = 9'b110100101;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100, OP_CBNZ = 8'b10110101;
    localparam logic [5:0]  OP_B    = 6'b000101, OP_BL = 6'b100101;

    logic [63:0] pc_q, pc_d;
    logic [3:0]  flags_q, flags_d;
    logic [63:0] ram_q [RAM_WORDS];

    logic [63:0] regAout, regBout, ALUout, ramOut, programCounterOut;
    logic [63:0] constantValue, regFileDataInput;
    logic [31:0] romOut, controlWord;
    logic [3:0]  signalBits;
    logic        enableAluData, enableRegAData, enableRamData, enablePcData;

    logic [4:0]  da, sa, sb;
    logic [3:0]  fs;
    logic [1:0]  pc_sel;
    logic        reg_write, ram_write, bsel, en_alu, en_ram, en_pc, en_rega;
    logic        status_load, cb_pol;

    assign programCounterOut = pc_q;
    assign signalBits        = flags_q;
    assign romOut            = ROM_IMAGE[pc_q[ROM_AW+1:2]];

    always_comb begin
        da = 5'd31; sa = 5'd31; sb = 5'd31; fs = FS_AND; pc_sel = 2'd0;
        reg_write = 1'b0; ram_write = 1'b0; bsel = 1'b0; en_alu = 1'b0;
        en_ram = 1'b0; en_pc = 1'b0; en_rega = 1'b0; status_load = 1'b0;
        cb_pol = 1'b0; constantValue = '0;
        case (romOut[31:21])
            OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_ADDS, OP_SUBS: begin
                da = romOut[4:0]; sa = romOut[9:5]; sb = romOut[20:16];
                reg_write = 1'b1; en_alu = 1'b1;
                case (romOut[31:21])
                    OP_ADD, OP_ADDS: fs = FS_ADD;
                    OP_SUB, OP_SUBS: fs = FS_SUB;
                    OP_ORR:          fs = FS_ORR;
                    OP_EOR:          fs = FS_EOR;
                    default:         fs = FS_AND;
                endcase
                status_load = (romOut[31:21] == OP_ADDS) || (romOut[31:21] == OP_SUBS);
            end
            OP_LSL, OP_LSR: begin
                da = romOut[4:0]; sa = romOut[9:5]; bsel = 1'b1;
                constantValue = {58'd0, romOut[15:10]};
                fs = (romOut[21]) ? FS_LSL : FS_LSR;
                reg_write = 1'b1; en_alu = 1'b1;
            end
            OP_LDUR, OP_STUR: begin
                sa = romOut[9:5]; bsel = 1'b1; fs = FS_ADD;
                constantValue = 64'($signed(romOut[20:12]));
                if (romOut[22]) begin
                    da = romOut[4:0]; reg_write = 1'b1; en_ram = 1'b1;
                end else begin
                    sb = romOut[4:0]; ram_write = 1'b1;
                end
            end
            default: begin
                if (romOut[31:22] inside {OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI, OP_EORI}) begin
                    da = romOut[4:0]; sa = romOut[9:5]; bsel = 1'b1;
                    constantValue = {52'd0, romOut[21:10]};
                    reg_write = 1'b1; en_alu = 1'b1;
                    case (romOut[31:22])
                        OP_ADDI: fs = FS_ADD;
                        OP_SUBI: fs = FS_SUB;
                        OP_ORRI: fs = FS_ORR;
                        OP_EORI: fs = FS_EOR;
                        default: fs = FS_AND;
                    endcase
                end else if (romOut[31:23] == OP_MOVZ) begin
                    da = romOut[4:0]; bsel = 1'b1; fs = FS_PSB;
                    constantValue = {48'd0, romOut[20:5]} << {romOut[22:21], 4'b0000};
                    reg_write = 1'b1; en_alu = 1'b1;
                end else if (romOut[31:24] == OP_CBZ || romOut[31:24] == OP_CBNZ) begin
                    // Rt is routed through the ALU as pass-B so its zero flag drives the branch.
                    sb = romOut[4:0]; fs = FS_PSB; pc_sel = 2'd2;
                    cb_pol = romOut[24];
                    constantValue = 64'($signed(romOut[23:5]));
                end else if (romOut[30:26] == OP_B[4:0]) begin
                    pc_sel = 2'd1;
                    constantValue = 64'($signed(romOut[25:0]));
                    if (romOut[31]) begin
                        da = 5'd30; reg_write = 1'b1; en_pc = 1'b1;
                    end
                end
            end
        endcase
    end

    assign controlWord = {2'b00, cb_pol, status_load, pc_sel, en_rega, en_pc, en_ram,
                          en_alu, bsel, ram_write, reg_write, fs, sb, sa, da};

    assign enableAluData  = controlWord[22];
    assign enableRamData  = controlWord[23];
    assign enablePcData   = controlWord[24];
    assign enableRegAData = controlWord[25];

    regfile regFile (
        .clk_i  (clock),
        .rst_ni (reset),
        .we_i   (controlWord[19]),
        .wa_i   (controlWord[4:0]),
        .wd_i   (regFileDataInput),
        .ra_i   (controlWord[9:5]),
        .rb_i   (controlWord[14:10]),
        .a_o    (regAout),
        .b_o    (regBout)
    );

    logic [63:0] alu_b;
    logic [64:0] alu_sum;
    logic        alu_c, alu_v, alu_z;

    assign alu_b = controlWord[21] ? constantValue : regBout;

    always_comb begin
        ALUout = '0; alu_sum = '0; alu_c = 1'b0; alu_v = 1'b0;
        case (controlWord[18:15])
            FS_AND: ALUout = regAout & alu_b;
            FS_ORR: ALUout = regAout | alu_b;
            FS_ADD: begin
                alu_sum = {1'b0, regAout} + {1'b0, alu_b};
                ALUout  = alu_sum[63:0];
                alu_c   = alu_sum[64];
                alu_v   = (regAout[63] == alu_b[63]) && (alu_sum[63] != regAout[63]);
            end
            FS_SUB: begin
                alu_sum = {1'b0, regAout} + {1'b0, ~alu_b} + 65'd1;
                ALUout  = alu_sum[63:0];
                alu_c   = alu_sum[64];
                alu_v   = (regAout[63] != alu_b[63]) && (alu_sum[63] != regAout[63]);
            end
            FS_EOR: ALUout = regAout ^ alu_b;
            FS_LSL: ALUout = regAout << alu_b[5:0];
            FS_LSR: ALUout = regAout >> alu_b[5:0];
            FS_PSB: ALUout = alu_b;
            default: ALUout = '0;
        endcase
    end

    assign alu_z = (ALUout == 64'd0);

    logic [RAM_AW-1:0] ram_idx;
    assign ram_idx = ALUout[RAM_AW+2:3];
    assign ramOut  = ram_q[ram_idx];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RAM_WORDS; i++) ram_q[i] <= '0;
        end else if (controlWord[20]) begin
            ram_q[ram_idx] <= regBout;
        end
    end

    logic [63:0] pc_plus4, pc_branch;
    logic        cb_taken;

    assign pc_plus4  = pc_q + 64'd4;
    assign pc_branch = pc_q + (constantValue << 2);
    assign cb_taken  = controlWord[29] ? !alu_z : alu_z;

    assign regFileDataInput = ({64{enableAluData}}  & ALUout)
                            | ({64{enableRamData}}  & ramOut)
                            | ({64{enableRegAData}} & regAout)
                            | ({64{enablePcData}}   & pc_plus4);

    always_comb begin
        case (controlWord[27:26])
            2'd1:    pc_d = pc_branch;
            2'd2:    pc_d = cb_taken ? pc_branch : pc_plus4;
            default: pc_d = pc_plus4;
        endcase
        flags_d = controlWord[28] ? {alu_v, alu_c, ALUout[63], alu_z} : flags_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q    <= '0;
            flags_q <= '0;
        end else begin
            pc_q    <= pc_d;
            flags_q <= flags_d;
        end
    end

    logic unused_ok;
    assign unused_ok = ^controlWord[31:30];
endmodule

// File: tb/tb_top_level.sv
// Runs a fixed LEGv8 program through top_level and checks architectural state
// after each instruction against a table of expected results.

module tb_top_level;
    localparam logic [10:0] ADD  = 11'b10001011000, SUB  = 11'b11001011000,
                            AND_ = 11'b10001010000, ORR  = 11'b10101010000,
                            EOR  = 11'b11001010000, ADDS = 11'b10101011000,
                            SUBS = 11'b11101011000, LSL  = 11'b11010011011,
                            LSR  = 11'b11010011010, LDUR = 11'b11111000010,
                            STUR = 11'b11111000000;
    localparam logic [9:0]  ADDI = 10'b1001000100, SUBI = 10'b1101000100,
                            ANDI = 10'b1001001000, ORRI = 10'b1011001000,
                            EORI = 10'b1101001000;

    function automatic logic [31:0] r_t(logic [10:0] op, logic [4:0] rm, logic [5:0] sh,
                                        logic [4:0] rn, logic [4:0] rd);
        return {op, rm, sh, rn, rd};
    endfunction
    function automatic logic [31:0] i_t(logic [9:0] op, logic [11:0] imm, logic [4:0] rn,
                                        logic [4:0] rd);
        return {op, imm, rn, rd};
    endfunction
    function automatic logic [31:0] d_t(logic [10:0] op, logic [8:0] imm, logic [4:0] rn,
                                        logic [4:0] rt);
        return {op, imm, 2'b00, rn, rt};
    endfunction
    function automatic logic [31:0] cb_t(logic [7:0] op, logic [18:0] imm, logic [4:0] rt);
        return {op, imm, rt};
    endfunction

    localparam logic [31:0] PROG [64] = '{
        0:  i_t(ADDI, 12'd5, 5'd31, 5'd1),
        1:  i_t(ADDI, 12'd7, 5'd31, 5'd2),
        2:  r_t(ADD,  5'd2, 6'd0, 5'd1, 5'd3),
        3:  r_t(SUBS, 5'd2, 6'd0, 5'd1, 5'd4),
        4:  r_t(SUBS, 5'd1, 6'd0, 5'd1, 5'd5),
        5:  d_t(STUR, 9'd8, 5'd31, 5'd3),
        6:  d_t(LDUR, 9'd8, 5'd31, 5'd6),
        7:  i_t(ADDI, 12'd9, 5'd31, 5'd31),
        8:  cb_t(8'b10110100, 19'd2, 5'd31),
        9:  i_t(ADDI, 12'd1, 5'd31, 5'd7),
        10: cb_t(8'b10110101, 19'd5, 5'd31),
        11: {9'b110100101, 2'd1, 16'h1234, 5'd8},
        12: {6'b100101, 26'd4},
        13: i_t(ADDI, 12'd2, 5'd31, 5'd7),
        14: i_t(ADDI, 12'd2, 5'd31, 5'd7),
        15: i_t(ADDI, 12'd2, 5'd31, 5'd7),
        16: r_t(ORR,  5'd2, 6'd0, 5'd1, 5'd9),
        17: r_t(AND_, 5'd2, 6'd0, 5'd1, 5'd10),
        18: r_t(EOR,  5'd2, 6'd0, 5'd1, 5'd11),
        19: r_t(LSL,  5'd0, 6'd4, 5'd1, 5'd12),
        20: r_t(LSR,  5'd0, 6'd16, 5'd8, 5'd13),
        21: r_t(ADDS, 5'd2, 6'd0, 5'd1, 5'd14),
        22: r_t(SUBS, 5'd1, 6'd0, 5'd1, 5'd16),
        23: r_t(SUB,  5'd1, 6'd0, 5'd2, 5'd15),
        24: i_t(ANDI, 12'd3, 5'd2, 5'd17),
        25: i_t(ORRI, 12'd8, 5'd1, 5'd18),
        26: i_t(EORI, 12'd5, 5'd2, 5'd19),
        27: i_t(SUBI, 12'd10, 5'd2, 5'd20),
        28: d_t(STUR, 9'h1FB, 5'd1, 5'd20),
        29: d_t(LDUR, 9'd0, 5'd31, 5'd21),
        30: {6'b000101, 26'd0},
        default: 32'h0
    };

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    top_level #(.ROM_IMAGE(PROG)) dut (
        .clock (clock),
        .reset (reset)
    );

    typedef struct {
        logic [63:0] pc;
        logic [4:0]  rx;
        logic [63:0] val;
        logic [3:0]  flags;
        logic [63:0] next_pc;
        string       name;
    } step_t;

    step_t tbl[$];
    step_t exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic add(input logic [63:0] pc, input int rx, input logic [63:0] v,
                       input logic [3:0] f, input logic [63:0] npc, input string n);
        step_t s;
        s.pc = pc; s.rx = 5'(rx); s.val = v; s.flags = f; s.next_pc = npc; s.name = n;
        tbl.push_back(s);
    endtask

    initial begin
        step_t e;
        add('h00, 1,  64'd5,                 4'b0000, 'h04, "addi_x1");
        add('h04, 2,  64'd7,                 4'b0000, 'h08, "addi_x2");
        add('h08, 3,  64'd12,                4'b0000, 'h0C, "add_x3");
        add('h0C, 4,  64'hFFFFFFFFFFFFFFFE,  4'b0010, 'h10, "subs_neg");
        add('h10, 5,  64'd0,                 4'b0101, 'h14, "subs_zero");
        add('h14, 3,  64'd12,                4'b0101, 'h18, "stur");
        add('h18, 6,  64'd12,                4'b0101, 'h1C, "ldur");
        add('h1C, 31, 64'd0,                 4'b0101, 'h20, "write_xzr");
        add('h20, 7,  64'd0,                 4'b0101, 'h28, "cbz_taken");
        add('h28, 7,  64'd0,                 4'b0101, 'h2C, "cbnz_fall");
        add('h2C, 8,  64'h12340000,          4'b0101, 'h30, "movz");
        add('h30, 30, 64'h34,                4'b0101, 'h40, "bl");
        add('h40, 9,  64'd7,                 4'b0101, 'h44, "orr");
        add('h44, 10, 64'd5,                 4'b0101, 'h48, "and");
        add('h48, 11, 64'd2,                 4'b0101, 'h4C, "eor");
        add('h4C, 12, 64'd80,                4'b0101, 'h50, "lsl");
        add('h50, 13, 64'h1234,              4'b0101, 'h54, "lsr");
        add('h54, 14, 64'd12,                4'b0000, 'h58, "adds");
        add('h58, 16, 64'd0,                 4'b0101, 'h5C, "subs_again");
        add('h5C, 15, 64'd2,                 4'b0101, 'h60, "sub_keeps_flags");
        add('h60, 17, 64'd3,                 4'b0101, 'h64, "andi");
        add('h64, 18, 64'd13,                4'b0101, 'h68, "orri");
        add('h68, 19, 64'd2,                 4'b0101, 'h6C, "eori");
        add('h6C, 20, 64'hFFFFFFFFFFFFFFFD,  4'b0101, 'h70, "subi_neg");
        add('h70, 20, 64'hFFFFFFFFFFFFFFFD,  4'b0101, 'h74, "stur_negoff");
        add('h74, 21, 64'hFFFFFFFFFFFFFFFD,  4'b0101, 'h78, "ldur_addr0");
        add('h78, 7,  64'd0,                 4'b0101, 'h78, "b_self");

        // Reset held low for three cycles.
        repeat (3) @(posedge clock);
        #1;
        chk("rst_pc", dut.programCounterOut, 64'd0);
        chk("rst_flags", 64'(dut.signalBits), 64'd0);
        for (int i = 0; i < 32; i++) chk($sformatf("rst_x%0d", i), dut.regFile.registers[i], 64'd0);

        @(negedge clock);
        reset = 1'b1;

        foreach (tbl[i]) begin
            chk({tbl[i].name, "_pc_before"}, dut.programCounterOut, tbl[i].pc);
            if (tbl[i].pc == 64'h08) begin
                chk("add_en_alu", 64'(dut.enableAluData), 64'd1);
                chk("add_bus", dut.regFileDataInput, 64'd12);
                chk("add_aluout", dut.ALUout, 64'd12);
            end
            if (tbl[i].pc == 64'h18) begin
                chk("ldur_en_ram", 64'(dut.enableRamData), 64'd1);
                chk("ldur_ramout", dut.ramOut, 64'd12);
                chk("ldur_bus", dut.regFileDataInput, 64'd12);
            end
            if (tbl[i].pc == 64'h30) begin
                chk("bl_en_pc", 64'(dut.enablePcData), 64'd1);
                chk("bl_bus", dut.regFileDataInput, 64'h34);
            end
            exp_q.push_back(tbl[i]);
            @(posedge clock);
            #1;
            e = exp_q.pop_front();
            chk({e.name, "_reg"}, dut.regFile.registers[e.rx], e.val);
            chk({e.name, "_flags"}, 64'(dut.signalBits), 64'(e.flags));
            chk({e.name, "_next_pc"}, dut.programCounterOut, e.next_pc);
        end

        // Skipped instructions must never have written X7; X31 stays zero.
        chk("x7_untouched", dut.regFile.registers[7], 64'd0);
        chk("x31_zero", dut.regFile.registers[31], 64'd0);

        // Asynchronous reset in the middle of the low clock phase.
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("async_pc", dut.programCounterOut, 64'd0);
        chk("async_x1", dut.regFile.registers[1], 64'd0);
        chk("async_x30", dut.regFile.registers[30], 64'd0);
        chk("async_x21", dut.regFile.registers[21], 64'd0);
        chk("async_flags", 64'(dut.signalBits), 64'd0);
        chk("async_ram0", dut.ramOut, 64'd0);
        repeat (2) @(posedge clock);
        #1;
        chk("held_pc", dut.programCounterOut, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("restart_pc", dut.programCounterOut, 64'd4);
        chk("restart_x1", dut.regFile.registers[1], 64'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
